score_controller: RTL
=====================

SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 Parameter WIN_SCORE, default 11, points that end a game; legal range 1..15.
REQ-002 Parameter SERVE_DELAY_FRAMES, default 60, frames waited before each serve; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 vsync  input  1  vertical sync level; each 0->1 transition is one frame tick.
REQ-006 start  input  1  player start button, level; each 0->1 transition is one start event.
REQ-007 miss_left  input  1  ball has left the playfield at the left edge, level; each 0->1 transition is one left miss.
REQ-008 miss_right  input  1  ball has left the playfield at the right edge, level; each 0->1 transition is one right miss.
REQ-009 counter_left  output  4  left player score, unsigned binary, feeds the score display.
REQ-010 counter_right  output  4  right player score, unsigned binary, feeds the score display.
REQ-011 ball_enable  output  1  ball motion and collision are enabled.
REQ-012 serve_pulse  output  1  one-cycle strobe that launches the ball.
REQ-013 serve_left  output  1  launch direction, valid when serve_pulse is high: 1 = toward left, 0 = toward right.
REQ-014 game_over  output  1  a player has reached WIN_SCORE.

Function
REQ-015 Edge detection shall register vsync, start, miss_left and miss_right once, and define each event as current & ~registered, giving 1-cycle detection latency.
REQ-016 The FSM states shall be IDLE, SERVE_WAIT, PLAY and GAME_OVER.
REQ-017 In IDLE or GAME_OVER, a start event shall, on the next edge, clear both counters, clear game_over, clear the frame counter, set serve_left=0, and enter SERVE_WAIT.
REQ-018 Start events in SERVE_WAIT or PLAY shall be ignored.
REQ-019 In SERVE_WAIT, the 8-bit frame counter shall increment on each frame tick.
REQ-020 When the frame counter reaches SERVE_DELAY_FRAMES, then on that next edge: serve_pulse=1 for exactly one cycle, ball_enable=1, frame counter cleared, state becomes PLAY.
REQ-021 In PLAY, a left-miss event shall increment counter_right, and a right-miss event shall increment counter_left.
REQ-022 A scoring event in PLAY shall also, on the same edge, deassert ball_enable.
REQ-023 After a left miss, serve_left shall be set to 1 (the serve goes to the player who conceded); after a right miss it shall be set to 0.
REQ-024 If the incremented score equals WIN_SCORE, the state shall become GAME_OVER and game_over=1 on that edge; otherwise the state shall become SERVE_WAIT with the frame counter cleared.
REQ-025 Simultaneous left- and right-miss events in one cycle shall be ignored: no score change and no state change.
REQ-026 Miss events outside PLAY shall be ignored.
REQ-027 The counters shall saturate at 15 and never wrap; they only change as described in REQ-017 and REQ-021.
REQ-028 In GAME_OVER, counters shall hold their final values, and ball_enable and serve_pulse shall be 0.
REQ-029 A frame tick coinciding with a start event in IDLE shall not be counted: the frame counter is 0 on entry to SERVE_WAIT.

Reset
REQ-030 When reset is high at a clock edge, then on that edge: state=IDLE, counter_left=0, counter_right=0, ball_enable=0, serve_pulse=0, serve_left=0, game_over=0, frame counter=0, and all edge-detect registers=0.
REQ-031 Reset shall take priority over every event in the same cycle, including mid-PLAY and mid-SERVE_WAIT.
REQ-032 Inputs that are already high when reset releases shall produce no event until they fall and rise again.

Verification
REQ-033 Serve timing: reset, start pulse, then 60 vsync rising edges -> exactly one serve_pulse with serve_left=0, following the 60th tick's detection; ball_enable=1; no serve_pulse before that.
REQ-034 Scoring: in PLAY, miss_left rises -> counter_right 0->1 and ball_enable=0 one cycle after detection; the next serve_pulse after 60 frames has serve_left=1.
REQ-035 Win: drive counter_left to 10, then a right miss -> counter_left=11, game_over=1, ball_enable=0; further misses and vsync ticks leave all outputs unchanged.
REQ-036 Simultaneous misses: miss_left and miss_right rise in the same cycle during PLAY -> both counters unchanged, state stays PLAY, ball_enable stays 1.
REQ-037 Reset mid-game: with counters at 5/7 in SERVE_WAIT, assert reset for one cycle -> all outputs 0 and state IDLE; vsync ticks without a start produce no serve_pulse.
REQ-038 Restart: in GAME_OVER, a start event -> counters 0/0, game_over=0, state SERVE_WAIT; a start held high continuously produces only one restart.

Source files
------------

// File: rtl/score_controller.sv
// Score and serve sequencer for a two-player paddle game: counts misses,
// paces each serve by video frames and flags the end of the game.
module score_controller #(
   parameter int WIN_SCORE          = 11,
   parameter int SERVE_DELAY_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       start,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic [3:0] counter_left,
   output logic [3:0] counter_right,
   output logic       ball_enable,
   output logic       serve_pulse,
   output logic       serve_left,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, SERVE_WAIT, PLAY, GAME_OVER} state_t;

   localparam logic [3:0] WIN   = 4'(WIN_SCORE);
   localparam logic [7:0] DELAY = 8'(SERVE_DELAY_FRAMES);

   state_t     state;
   logic [7:0] frame_cnt;
   logic       vsync_q, start_q, miss_left_q, miss_right_q;
   logic       armed;
   logic       frame_tick, start_evt, left_evt, right_evt;
   logic [3:0] left_next, right_next;

   // The edge registers hold 0 after reset, so events stay masked for the
   // first cycle while they capture the real input levels.
   assign frame_tick = armed & vsync      & ~vsync_q;
   assign start_evt  = armed & start      & ~start_q;
   assign left_evt   = armed & miss_left  & ~miss_left_q;
   assign right_evt  = armed & miss_right & ~miss_right_q;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hf) ? v : v + 4'd1;
   endfunction

   assign left_next  = sat_inc(counter_left);
   assign right_next = sat_inc(counter_right);

   // NOTE: every register in this block uses <= so all updates see the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         frame_cnt     <= '0;
         vsync_q       <= 1'b0;
         start_q       <= 1'b0;
         miss_left_q   <= 1'b0;
         miss_right_q  <= 1'b0;
         armed         <= 1'b0;
         counter_left  <= '0;
         counter_right <= '0;
         ball_enable   <= 1'b0;
         serve_pulse   <= 1'b0;
         serve_left    <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         start_q      <= start;
         miss_left_q  <= miss_left;
         miss_right_q <= miss_right;
         armed        <= 1'b1;
         serve_pulse  <= 1'b0;

         case (state)
            IDLE, GAME_OVER: begin
               ball_enable <= 1'b0;
               if (start_evt) begin
                  counter_left  <= '0;
                  counter_right <= '0;
                  game_over     <= 1'b0;
                  frame_cnt     <= '0;
                  serve_left    <= 1'b0;
                  state         <= SERVE_WAIT;
               end
            end

            SERVE_WAIT: begin
               if (frame_cnt == DELAY) begin
                  serve_pulse <= 1'b1;
                  ball_enable <= 1'b1;
                  frame_cnt   <= '0;
                  state       <= PLAY;
               end else if (frame_tick) begin
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end

            PLAY: begin
               // A left miss scores for the right player and the conceding
               // side serves next; simultaneous misses cancel out.
               if (left_evt && !right_evt) begin
                  counter_right <= right_next;
                  serve_left    <= 1'b1;
                  ball_enable   <= 1'b0;
                  frame_cnt     <= '0;
                  if (right_next == WIN) begin
                     game_over <= 1'b1;
                     state     <= GAME_OVER;
                  end else begin
                     state <= SERVE_WAIT;
                  end
               end else if (right_evt && !left_evt) begin
                  counter_left <= left_next;
                  serve_left   <= 1'b0;
                  ball_enable  <= 1'b0;
                  frame_cnt    <= '0;
                  if (left_next == WIN) begin
                     game_over <= 1'b1;
                     state     <= GAME_OVER;
                  end else begin
                     state <= SERVE_WAIT;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
